// File: rtl/sha256_pkg.sv
// Shared constants, pad byte and state encoding for the SHA-256 message padder.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_W     = 512;
  localparam int BLOCK_WORDS = 16;
  localparam int LEN_FIELD_W = 64;
  localparam int LAST_FIT_P  = 55;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    EMIT       = 2'd1,
    PAD        = 2'd2,
    EMIT_FINAL = 2'd3
  } pad_state_t;

endpackage

// File: rtl/sha256_pad_word.sv
// Masks the unused tail bytes of a big-endian word and inserts the 0x80 pad byte
// right after the last valid byte; carry flags that the pad byte belongs to the next word.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [2:0]        nbytes,
  output logic [WORD_W-1:0] padded,
  output logic              carry
);

  always_comb begin
    padded = word;
    carry  = (nbytes == 3'd4);
    case (nbytes)
      3'd1:    padded = {word[31:24], PAD_BYTE, 16'h0000};
      3'd2:    padded = {word[31:16], PAD_BYTE, 8'h00};
      3'd3:    padded = {word[31:8], PAD_BYTE};
      default: padded = word;
    endcase
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: packs 32-bit words into 512-bit blocks and appends 0x80,
// zero fill and the 64-bit bit-length. Optional input checking via SHA256_PADDER_CHECK_EN.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
)
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                valid_i,
  input  logic [WORD_W-1:0]   data_i,
  input  logic [2:0]          bytes_i,
  input  logic                last_i,
  output logic                ready_o,
  output logic                valid_o,
  output logic [BLOCK_W-1:0]  block_o,
  output logic                first_o,
  output logic                last_o,
  input  logic                ready_i
`ifdef SHA256_PADDER_CHECK_EN
  ,
  output logic                err_o
`endif
);

  pad_state_t state, state_next;

  logic [WORD_W-1:0] blk [BLOCK_WORDS];
  logic [3:0]        widx;
  logic [LEN_W-1:0]  len;
  logic              first_flag;
  logic              pad_pending;
  logic              pad_at_word0;

  logic [2:0]        eff_bytes;
  logic              in_xfer;
  logic              out_xfer;
  logic [6:0]        p;
  logic              fits;
  logic              p64;
  logic [LEN_W-1:0]  len_sum;
  logic [LEN_FIELD_W-1:0] field_sum;
  logic [LEN_FIELD_W-1:0] field_len;
  logic [WORD_W-1:0] padded_word;
  logic              carry;

  function automatic logic [LEN_FIELD_W-1:0] to_field(input logic [LEN_W-1:0] v);
    logic [LEN_FIELD_W-1:0] f;
    f = '0;
    f[LEN_W-1:0] = v;
    return f;
  endfunction

`ifdef SHA256_PADDER_CHECK_EN
  logic illegal;
  logic err;

  assign illegal   = (bytes_i == 3'd0) || (bytes_i > 3'd4) || ((bytes_i != 3'd4) && !last_i);
  assign eff_bytes = illegal ? 3'd4 : bytes_i;
  assign err_o     = err;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      err <= 1'b0;
    else if (in_xfer && illegal)
      err <= 1'b1;
  end
`else
  assign eff_bytes = bytes_i;
`endif

  assign in_xfer   = valid_i && ready_o;
  assign out_xfer  = valid_o && ready_i;
  assign p         = {1'b0, widx, 2'b00} + {4'b0000, eff_bytes};
  assign fits      = (p <= 7'(LAST_FIT_P));
  assign p64       = (p == 7'd64);
  assign len_sum   = len + {{(LEN_W-6){1'b0}}, eff_bytes, 3'b000};
  assign field_sum = to_field(len_sum);
  assign field_len = to_field(len);

  sha256_pad_word u_pad_word (
    .word   (data_i),
    .nbytes (eff_bytes),
    .padded (padded_word),
    .carry  (carry)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      state <= FILL;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_o    = (state == FILL) && !reset_i;
    valid_o    = (state == EMIT) || (state == EMIT_FINAL);
    first_o    = valid_o && first_flag;
    last_o     = (state == EMIT_FINAL);
    case (state)
      FILL: begin
        if (in_xfer) begin
          if (last_i)
            state_next = fits ? EMIT_FINAL : EMIT;
          else if (widx == 4'd15)
            state_next = EMIT;
        end
      end
      EMIT: begin
        if (out_xfer)
          state_next = pad_pending ? PAD : FILL;
      end
      PAD:        state_next = EMIT_FINAL;
      EMIT_FINAL: begin
        if (out_xfer)
          state_next = FILL;
      end
      default:    state_next = FILL;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < BLOCK_WORDS; i++)
        blk[i] <= '0;
      widx         <= '0;
      len          <= '0;
      first_flag   <= 1'b1;
      pad_pending  <= 1'b0;
      pad_at_word0 <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_xfer) begin
            len <= len_sum;
            if (last_i) begin
              widx         <= '0;
              pad_pending  <= !fits;
              pad_at_word0 <= p64;
              // Words before widx keep the message; everything after is zero or pad.
              for (int i = 0; i < BLOCK_WORDS; i++) begin
                if (i == int'(widx))
                  blk[i] <= padded_word;
                else if ((i == int'(widx) + 1) && carry)
                  blk[i] <= {PAD_BYTE, 24'h000000};
                else if (i > int'(widx))
                  blk[i] <= '0;
              end
              if (fits) begin
                blk[14] <= field_sum[63:32];
                blk[15] <= field_sum[31:0];
              end
            end else begin
              blk[widx]   <= data_i;
              widx        <= widx + 4'd1;
              pad_pending <= 1'b0;
            end
          end
        end
        PAD: begin
          for (int i = 0; i < BLOCK_WORDS; i++)
            blk[i] <= '0;
          if (pad_at_word0)
            blk[0] <= {PAD_BYTE, 24'h000000};
          blk[14]     <= field_len[63:32];
          blk[15]     <= field_len[31:0];
          pad_pending <= 1'b0;
        end
        EMIT, EMIT_FINAL: begin
          if (out_xfer) begin
            first_flag <= (state == EMIT_FINAL);
            if (state == EMIT_FINAL)
              len <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_pack
      assign block_o[BLOCK_W-1-WORD_W*gi -: WORD_W] = blk[gi];
    end
  endgenerate

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: byte-level FIPS padding model, per-transfer compare
// process, and literal block expectations for the directed scenarios.
module tb_sha256_msg_padder;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         valid_i;
  logic [31:0]  data_i;
  logic [2:0]   bytes_i;
  logic         last_i;
  logic         ready_o;
  logic         valid_o;
  logic [511:0] block_o;
  logic         first_o;
  logic         last_o;
  logic         ready_i;

  always #5 clk_i = ~clk_i;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .bytes_i (bytes_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .block_o (block_o),
    .first_o (first_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  typedef struct {
    logic [511:0] blk;
    bit           first;
    bit           last;
  } exp_t;

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

  exp_t         model_q[$];
  logic [511:0] cap_blk[$];
  bit           cap_first[$];
  bit           cap_last[$];
  int           cap_cyc[$];
  byte unsigned msg[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int xfer_cnt = 0;
  int acc_cyc  = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] wd(input logic [511:0] b, input int i);
    return b[511-32*i -: 32];
  endfunction

  // Padding straight from the byte-level rule: msg || 0x80 || 0* || len64, cut into 64-byte blocks.
  task automatic model_msg();
    byte unsigned pb[$];
    logic [63:0]  bl;
    exp_t         e;
    int           nb;
    pb = msg;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) pb.push_back(bl[8*k +: 8]);
    nb = pb.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int j = 0; j < 64; j++) e.blk[511-8*j -: 8] = pb[b*64+j];
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      model_q.push_back(e);
    end
  endtask

  task automatic set_msg(input int n, input int seed);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'(seed + i * 7));
  endtask

  task automatic set_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  task automatic drive(input int max_words);
    int n, nw, nd, t, nb;
    n  = msg.size();
    nw = (n + 3) / 4;
    nd = (max_words < nw) ? max_words : nw;
    for (int w = 0; w < nd; w++) begin
      data_i = '0;
      for (int k = 0; k < 4; k++)
        if (4*w + k < n) data_i[31-8*k -: 8] = msg[4*w+k];
      nb      = (n - 4*w >= 4) ? 4 : n - 4*w;
      bytes_i = 3'(nb);
      last_i  = (w == nw - 1);
      valid_i = 1'b1;
      t = 0;
      @(negedge clk_i);
      while (!ready_o && t < 500) begin
        @(negedge clk_i);
        t++;
      end
      if (!ready_o) timeout_fail("accept_timeout");
      acc_cyc = cyc;
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic send(input int n, input int seed);
    set_msg(n, seed);
    model_msg();
    drive(1000);
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk_i);
    #2;
    while ((model_q.size() != 0 || valid_o) && t < 2000) begin
      @(negedge clk_i);
      #2;
      t++;
    end
    if (model_q.size() != 0 || valid_o) timeout_fail("drain_timeout");
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!valid_o && t < 200) begin
      @(negedge clk_i);
      #1;
      t++;
    end
    if (!valid_o) timeout_fail("valid_timeout");
  endtask

  task automatic clear_cap();
    cap_blk.delete();
    cap_first.delete();
    cap_last.delete();
    cap_cyc.delete();
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Compare process: every output transfer against the model, every stalled cycle for stability.
  initial begin : compare
    exp_t         e;
    logic [511:0] hold_blk;
    bit           hold_v;
    bit           hold_first, hold_last;
    hold_v = 0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        hold_v = 0;
      end else begin
        if (hold_v && valid_o) begin
          chk("hold_block", block_o, hold_blk);
          chk("hold_first", 512'(first_o), 512'(hold_first));
          chk("hold_last", 512'(last_o), 512'(hold_last));
        end
        hold_v = 0;
        if (valid_o && ready_i) begin
          if (model_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_block: got %0h required none", block_o);
          end else begin
            e = model_q.pop_front();
            chk("block", block_o, e.blk);
            chk("first", 512'(first_o), 512'(e.first));
            chk("last", 512'(last_o), 512'(e.last));
          end
          cap_blk.push_back(block_o);
          cap_first.push_back(first_o);
          cap_last.push_back(last_o);
          cap_cyc.push_back(cyc);
          xfer_cnt++;
          $display("block %0d: first=%0b last=%0b w0=%08h w15=%08h", xfer_cnt, first_o, last_o,
                   wd(block_o, 0), wd(block_o, 15));
        end else if (valid_o) begin
          hold_v     = 1;
          hold_blk   = block_o;
          hold_first = first_o;
          hold_last  = last_o;
        end
      end
    end
  end

  initial begin : main
    logic [511:0] snap;
    int           x0;
    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    bytes_i = 3'd0;
    last_i  = 1'b0;
    ready_i = 1'b1;

    repeat (2) @(negedge clk_i);
    chk("rst_valid", 512'(valid_o), 512'(0));
    chk("rst_ready", 512'(ready_o), 512'(0));
    chk("rst_block", block_o, '0);
    chk("rst_first", 512'(first_o), 512'(0));
    chk("rst_last", 512'(last_o), 512'(0));
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // "abc"
    clear_cap();
    set_abc();
    model_msg();
    chk("model_abc", model_q[0].blk, ABC);
    drive(1000);
    drain();
    chk("abc_nblk", 512'(cap_blk.size()), 512'(1));
    chk("abc_block", cap_blk[0], ABC);
    chk("abc_first", 512'(cap_first[0]), 512'(1));
    chk("abc_last", 512'(cap_last[0]), 512'(1));

    // 55 bytes: pad byte is the last byte of word 13
    clear_cap();
    send(55, 3);
    drain();
    chk("m55_nblk", 512'(cap_blk.size()), 512'(1));
    chk("m55_w13_lo", 512'(wd(cap_blk[0], 13) & 32'hFF), 512'(32'h80));
    chk("m55_w14", 512'(wd(cap_blk[0], 14)), 512'(0));
    chk("m55_w15", 512'(wd(cap_blk[0], 15)), 512'(32'h000001B8));

    // 56 bytes: pad byte opens word 14, length spills into a second block
    clear_cap();
    send(56, 5);
    drain();
    chk("m56_nblk", 512'(cap_blk.size()), 512'(2));
    chk("m56_b0_w14", 512'(wd(cap_blk[0], 14)), 512'(32'h80000000));
    chk("m56_b0_w15", 512'(wd(cap_blk[0], 15)), 512'(0));
    chk("m56_b0_last", 512'(cap_last[0]), 512'(0));
    chk("m56_b1_hi", 512'(cap_blk[1][511:32]), 512'(0));
    chk("m56_b1_w15", 512'(wd(cap_blk[1], 15)), 512'(32'h000001C0));
    chk("m56_b1_first", 512'(cap_first[1]), 512'(0));
    chk("m56_b1_last", 512'(cap_last[1]), 512'(1));
    chk("m56_pad_gap", 512'(cap_cyc[1] - cap_cyc[0]), 512'(2));

    // 64 bytes, then "abc" must start a fresh message
    clear_cap();
    send(64, 9);
    drain();
    chk("m64_nblk", 512'(cap_blk.size()), 512'(2));
    chk("m64_latency", 512'(cap_cyc[0] - acc_cyc), 512'(1));
    chk("m64_b1_w0", 512'(wd(cap_blk[1], 0)), 512'(32'h80000000));
    chk("m64_b1_mid", 512'(cap_blk[1][479:32]), 512'(0));
    chk("m64_b1_w15", 512'(wd(cap_blk[1], 15)), 512'(32'h00000200));
    clear_cap();
    set_abc();
    model_msg();
    drive(1000);
    drain();
    chk("post64_abc", cap_blk[0], ABC);
    chk("post64_first", 512'(cap_first[0]), 512'(1));

    // Backpressure: block held for 10 cycles while a stray word is offered
    clear_cap();
    ready_i = 1'b0;
    set_abc();
    model_msg();
    drive(1000);
    wait_valid();
    snap    = block_o;
    x0      = xfer_cnt;
    valid_i = 1'b1;
    data_i  = 32'hDEADBEEF;
    bytes_i = 3'd4;
    last_i  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      #1;
      chk("bp_valid", 512'(valid_o), 512'(1));
      chk("bp_ready", 512'(ready_o), 512'(0));
      chk("bp_block", block_o, snap);
    end
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    repeat (5) @(negedge clk_i);
    #1;
    chk("bp_single_xfer", 512'(xfer_cnt - x0), 512'(1));
    chk("bp_after_valid", 512'(valid_o), 512'(0));
    @(posedge clk_i);
    #1;
    send(20, 11);
    drain();

    // Reset mid-message, then reset while a block is being offered
    set_msg(40, 13);
    drive(5);
    reset_i = 1'b1;
    #1;
    chk("rst_mid_valid", 512'(valid_o), 512'(0));
    chk("rst_mid_ready", 512'(ready_o), 512'(0));
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    ready_i = 1'b0;
    set_abc();
    model_msg();
    drive(1000);
    wait_valid();
    reset_i = 1'b1;
    #1;
    chk("rst_emit_valid", 512'(valid_o), 512'(0));
    chk("rst_emit_block", block_o, '0);
    model_q.delete();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    ready_i = 1'b1;
    clear_cap();
    set_abc();
    model_msg();
    drive(1000);
    drain();
    chk("rst_abc_nblk", 512'(cap_blk.size()), 512'(1));
    chk("rst_abc_block", cap_blk[0], ABC);
    chk("rst_abc_first", 512'(cap_first[0]), 512'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 message scheduler.
- Accepts a byte-aligned message as a stream of big-endian 32-bit words and appends the FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit bit-length.
- Emits 512-bit blocks one at a time through a valid/ready handshake.
- Holds one block buffer and one message-length counter.

Parameters:
- LEN_W, 64: width of the bit-length counter. Allowed range is 32..64. The length field is zero-extended to 64 bits. Count wraps modulo 2^LEN_W.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- valid_i  in  1  input word valid
- data_i  in  32  message word; first byte in [31:24]
- bytes_i  in  3  valid bytes in data_i, 1..4; values below 4 allowed only with last_i
- last_i  in  1  final word of message
- ready_o  out  1  padder accepts a word this cycle
- valid_o  out  1  block_o valid
- block_o  out  512  padded block; word 0 in [511:480], word 15 in [31:0]
- first_o  out  1  block is the first block of its message
- last_o  out  1  block is the final block of its message
- ready_i  in  1  downstream accepts block

Behaviour:
- Reset, asynchronous: state=FILL, widx=0, len=0, first flag set, valid_o=0, ready_o=0 during reset, block_o=0, first_o=0, last_o=0. Any partial message is discarded. Reset may assert on any cycle; in-flight blocks are dropped.
- Transfer rules: an input transfer occurs when valid_i&ready_o. An output transfer occurs when valid_o&ready_i. ready_o=1 only in FILL.
- FILL:
  - Each transfer writes data_i to word widx, adds 8*bytes_i to len, and increments widx.
  - Non-last transfer at widx=15 → EMIT (data block, last_o=0).
  - Last transfer: bytes beyond bytes_i are zeroed, and 0x80 is placed at byte offset p = 4*widx+bytes_i. If p=64, no pad byte fits in this block.
  - Remaining words are zero-filled.
  - If p≤55: words 14-15 receive the final len (including this word) → EMIT_FINAL.
  - If p>55: → EMIT, then PAD.
- PAD: one cycle. Builds a block that is all zero except word 0 = 0x80000000 when p was 64, and words 14-15 = len → EMIT_FINAL.
- EMIT/EMIT_FINAL:
  - valid_o=1; block_o, first_o and last_o are stable until the transfer.
  - last_o=1 only in EMIT_FINAL.
  - On transfer: first flag clears.
  - From EMIT_FINAL: len=0, first flag sets, → FILL.
  - From EMIT: go to PAD if one is pending, else FILL with widx=0.
- Latency:
  - Word 16 accepted at cycle N → valid_o at N+1.
  - An extra pad block appears 2 cycles after the prior output transfer.
- Empty messages are not supported.
- Illegal inputs (bytes_i=0, bytes_i>4, or bytes_i<4 without last_i): behaviour undefined unless the optional feature is compiled in.

Optional Feature:
- Macro: SHA256_PADDER_CHECK_EN.
- With the macro:
  - Adds port err_o, out, 1, sticky.
  - err_o sets on an accepted word that is illegal. The word is treated as bytes_i=4.
  - err_o clears only on reset.
- Without the macro: no err_o port and no checking logic.

Decomposition:
- sha256_pkg:
  - block/word width constants
  - PAD_BYTE=8'h80
  - the padder state enum (FILL, EMIT, PAD, EMIT_FINAL)
  - LEN field width 64
- One sub-module: sha256_pad_word, combinational. Takes a word and a byte count, and returns the word with tail bytes masked and 0x80 inserted at the next byte.

Test Plan:
- "abc": data_i=0x61626300, bytes_i=3, last_i=1 → one block; word0=0x61626380, words1-14=0, word15=0x00000018; first_o=last_o=1.
- 55-byte message (13 full words + 3 bytes) → single block; word13 low byte=0x80, word14=0, word15=0x000001B8.
- 56-byte message (14 full words, last on word 14) → block 1: word14=0x80000000, word15=0, last_o=0. Block 2: words0-14=0, word15=0x000001C0, first_o=0, last_o=1.
- 64-byte message → data block, then a block with word0=0x80000000 and word15=0x00000200. Then an "abc" message follows with first_o=1 and correct length.
- Backpressure: ready_i=0 for 10 cycles during EMIT → valid_o held, block_o unchanged, ready_o=0, no input consumed. Release → single transfer.
- Reset after 5 words accepted → valid_o=0 immediately. Then "abc" → exactly the block from the first scenario.
